// File: rtl/trap_ctrl_unit_pkg.sv
// Shared constants and types for the trap control unit: CSR map, FSM encoding,
// and the exception capture payload handed from the FSM to the CSR file.
package trap_ctrl_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CSR_AW   = 12;
    localparam int unsigned STATE_W  = 2;
    localparam int unsigned MPP_BIT  = 11;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    localparam logic [STATE_W-1:0] IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] WAIT_REC = 2'd1;
    localparam logic [STATE_W-1:0] REDIRECT = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] mepc;
        logic [XLEN-1:0] mcause;
        logic [XLEN-1:0] mtval;
    } trap_capture_t;

endpackage

// File: rtl/trap_csr_regs.sv
// Machine trap CSR storage with combinational read mux, decode-side write port
// and an FSM-driven capture port for exception entry and mret.
module trap_csr_regs
    import trap_ctrl_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_2000
) (
    input  logic                clk,
    input  logic                rsn,
    input  logic                we,
    input  logic [CSR_AW-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                cap_en,
    input  trap_capture_t       cap,
    input  logic                cap_prev_priv,
    input  logic                mret_en,
    output logic [XLEN-1:0]     rdata,
    output logic [XLEN-1:0]     mtvec,
    output logic [XLEN-1:0]     mepc,
    output logic                prev_priv
);

    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;

    // Read mux reflects register contents, so a same-cycle write reads old data.
    always_comb begin
        rdata = '0;
        case (addr)
            CSR_MSTATUS: rdata[MPP_BIT] = prev_priv;
            CSR_MTVEC:   rdata = mtvec;
            CSR_MEPC:    rdata = mepc;
            CSR_MCAUSE:  rdata = mcause;
            CSR_MTVAL:   rdata = mtval;
            default:     rdata = '0;
        endcase
    end

    // Capture and write never coincide (FSM gates writes); mret owns MPP over a write.
    always_ff @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            mtvec     <= RESET_MTVEC;
            mepc      <= '0;
            mcause    <= '0;
            mtval     <= '0;
            prev_priv <= 1'b0;
        end else if (cap_en) begin
            mepc      <= cap.mepc;
            mcause    <= cap.mcause;
            mtval     <= cap.mtval;
            prev_priv <= cap_prev_priv;
        end else begin
            if (we) begin
                case (addr)
                    CSR_MSTATUS: prev_priv <= wdata[MPP_BIT];
                    CSR_MTVEC:   mtvec     <= {wdata[XLEN-1:2], 2'b00};
                    CSR_MEPC:    mepc      <= wdata;
                    CSR_MCAUSE:  mcause    <= wdata;
                    CSR_MTVAL:   mtval     <= wdata;
                    default:     ;
                endcase
            end
            if (mret_en) begin
                prev_priv <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl_unit.sv
// Precise-exception sequencer: flush on kill, hold decode during history-file
// rollback, capture trap CSRs, redirect fetch to mtvec; also handles mret.
module trap_ctrl_unit
    import trap_ctrl_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_2000,
    parameter int unsigned REC_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                hf_kill_instr_i,
    input  logic [XLEN-1:0]     hf_kill_pc_i,
    input  logic                hf_exc_occured_i,
    input  logic [XLEN-1:0]     hf_exc_mtval_i,
    input  logic [XLEN-1:0]     hf_exc_mepc_i,
    input  logic [XLEN-1:0]     hf_exc_mcause_i,
    input  logic                dec_mret_i,
    input  logic                dec_csr_we_i,
    input  logic [CSR_AW-1:0]   dec_csr_addr_i,
    input  logic [XLEN-1:0]     dec_csr_wdata_i,
    output logic [XLEN-1:0]     dec_csr_rdata_o,
    output logic                stall_decode_o,
    output logic                flush_pipe_o,
    output logic                redirect_val_o,
    output logic [XLEN-1:0]     redirect_pc_o,
    output logic                priv_o,
    output logic                timeout_err_o
);

    logic [STATE_W-1:0] state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               priv_next;
    logic               timeout_next;
    logic               flush_next;
    logic               stall_next;
    logic               redirect_val_next;
    logic [XLEN-1:0]    redirect_pc_next;

    logic               cap_en;
    logic               mret_en;
    logic               csr_we;
    trap_capture_t      cap;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;
    logic               prev_priv;

    // The faulting PC arrives on the exception bus; the kill PC is informational only.
    logic unused_kill_pc;
    assign unused_kill_pc = ^hf_kill_pc_i;

    assign cap = '{mepc: hf_exc_mepc_i, mcause: hf_exc_mcause_i, mtval: hf_exc_mtval_i};

    trap_csr_regs #(
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr (
        .clk           (clk_i),
        .rsn           (rsn_i),
        .we            (csr_we),
        .addr          (dec_csr_addr_i),
        .wdata         (dec_csr_wdata_i),
        .cap_en        (cap_en),
        .cap           (cap),
        .cap_prev_priv (priv_o),
        .mret_en       (mret_en),
        .rdata         (dec_csr_rdata_o),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .prev_priv     (prev_priv)
    );

    // Next-state and next-output logic; priority exc > kill > mret > CSR write.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        priv_next         = priv_o;
        timeout_next      = timeout_err_o;
        flush_next        = 1'b0;
        stall_next        = 1'b0;
        redirect_val_next = 1'b0;
        redirect_pc_next  = redirect_pc_o;
        cap_en            = 1'b0;
        mret_en           = 1'b0;
        csr_we            = 1'b0;

        case (state)
            IDLE: begin
                if (hf_exc_occured_i) begin
                    cap_en            = 1'b1;
                    priv_next         = 1'b1;
                    flush_next        = 1'b1;
                    stall_next        = 1'b1;
                    redirect_val_next = 1'b1;
                    redirect_pc_next  = mtvec;
                    state_next        = REDIRECT;
                end else if (hf_kill_instr_i) begin
                    flush_next = 1'b1;
                    stall_next = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT_REC;
                end else begin
                    csr_we = dec_csr_we_i;
                    if (dec_mret_i && priv_o) begin
                        mret_en           = 1'b1;
                        priv_next         = prev_priv;
                        redirect_val_next = 1'b1;
                        redirect_pc_next  = mepc;
                    end
                end
            end

            WAIT_REC: begin
                stall_next = 1'b1;
                cnt_next   = cnt + CNT_W'(1);
                if (hf_exc_occured_i) begin
                    cap_en            = 1'b1;
                    priv_next         = 1'b1;
                    redirect_val_next = 1'b1;
                    redirect_pc_next  = mtvec;
                    state_next        = REDIRECT;
                end else if (cnt == CNT_W'(REC_TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    stall_next   = 1'b0;
                    state_next   = IDLE;
                end
            end

            REDIRECT: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state          <= IDLE;
            cnt            <= '0;
            priv_o         <= 1'b1;
            timeout_err_o  <= 1'b0;
            flush_pipe_o   <= 1'b0;
            stall_decode_o <= 1'b0;
            redirect_val_o <= 1'b0;
            redirect_pc_o  <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            priv_o         <= priv_next;
            timeout_err_o  <= timeout_next;
            flush_pipe_o   <= flush_next;
            stall_decode_o <= stall_next;
            redirect_val_o <= redirect_val_next;
            redirect_pc_o  <= redirect_pc_next;
        end
    end

endmodule

// File: tb/tb_trap_ctrl_unit.sv
// Directed self-checking bench for trap_ctrl_unit: CSR access, exception entry,
// mret, recovery timeout, input priority and asynchronous reset.
module tb_trap_ctrl_unit;

    logic        clk = 1'b0;
    logic        rsn;
    logic        kill;
    logic [31:0] kill_pc;
    logic        exc;
    logic [31:0] exc_mtval, exc_mepc, exc_mcause;
    logic        mret;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        stall, flush, redirect_val, priv, timeout_err;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trap_ctrl_unit dut (
        .clk_i            (clk),
        .rsn_i            (rsn),
        .hf_kill_instr_i  (kill),
        .hf_kill_pc_i     (kill_pc),
        .hf_exc_occured_i (exc),
        .hf_exc_mtval_i   (exc_mtval),
        .hf_exc_mepc_i    (exc_mepc),
        .hf_exc_mcause_i  (exc_mcause),
        .dec_mret_i       (mret),
        .dec_csr_we_i     (csr_we),
        .dec_csr_addr_i   (csr_addr),
        .dec_csr_wdata_i  (csr_wdata),
        .dec_csr_rdata_o  (csr_rdata),
        .stall_decode_o   (stall),
        .flush_pipe_o     (flush),
        .redirect_val_o   (redirect_val),
        .redirect_pc_o    (redirect_pc),
        .priv_o           (priv),
        .timeout_err_o    (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
        csr_we   = 1'b0;
        csr_addr = addr;
        #1;
        data = csr_rdata;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rsn = 1'b0; kill = 0; kill_pc = '0; exc = 0; exc_mtval = '0; exc_mepc = '0;
        exc_mcause = '0; mret = 0; csr_we = 0; csr_addr = '0; csr_wdata = '0;
        tick(); tick();
        rsn = 1'b1;
        tick();
        n_checks++; if ({stall, flush, redirect_val, timeout_err} !== 4'b0000)
            $display("FAIL reset_outs: got %b want 0000", {stall, flush, redirect_val, timeout_err});
        else n_pass++;
        n_checks++; if (priv !== 1'b1) $display("FAIL reset_priv: got %b want 1", priv); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h0) $display("FAIL reset_rpc: got %h want 0", redirect_pc); else n_pass++;
        csr_read(12'h305, d);
        n_checks++; if (d !== 32'h2000) $display("FAIL reset_mtvec: got %h want 00002000", d); else n_pass++;
        csr_read(12'h300, d);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_mstatus: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_csr_rw();
        logic [31:0] d;
        csr_write(12'h305, 32'h4003);
        csr_read(12'h305, d);
        n_checks++; if (d !== 32'h4000) $display("FAIL mtvec_align: got %h want 00004000", d); else n_pass++;
        csr_write(12'h7C0, 32'hFFFF);
        csr_read(12'h7C0, d);
        n_checks++; if (d !== 32'h0) $display("FAIL unmapped: got %h want 0", d); else n_pass++;
        // read during write sees old value
        csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h5;
        #1;
        n_checks++; if (csr_rdata !== 32'h0) $display("FAIL rd_during_wr: got %h want 0", csr_rdata); else n_pass++;
        tick();
        csr_read(12'h342, d);
        n_checks++; if (d !== 32'h5) $display("FAIL mcause_wr: got %h want 5", d); else n_pass++;
    endtask

    task automatic test_exception();
        logic [31:0] d;
        int stall_cnt = 0;
        kill = 1'b1; kill_pc = 32'h100;
        tick();
        kill = 1'b0;
        n_checks++; if (flush !== 1'b1) $display("FAIL kill_flush: got %b want 1", flush); else n_pass++;
        if (stall) stall_cnt++;
        tick();
        n_checks++; if (flush !== 1'b0) $display("FAIL flush_pulse: got %b want 0", flush); else n_pass++;
        if (stall) stall_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (stall) stall_cnt++;
        end
        exc = 1'b1; exc_mepc = 32'h100; exc_mcause = 32'h2; exc_mtval = 32'hDEAD;
        tick();
        exc = 1'b0;
        if (stall) stall_cnt++;
        n_checks++; if (redirect_val !== 1'b1) $display("FAIL exc_rval: got %b want 1", redirect_val); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h4000) $display("FAIL exc_rpc: got %h want 00004000", redirect_pc); else n_pass++;
        tick();
        if (stall) stall_cnt++;
        n_checks++; if (stall_cnt != 6) $display("FAIL stall_len: got %0d want 6", stall_cnt); else n_pass++;
        n_checks++; if (redirect_val !== 1'b0) $display("FAIL rval_pulse: got %b want 0", redirect_val); else n_pass++;
        n_checks++; if (priv !== 1'b1) $display("FAIL exc_priv: got %b want 1", priv); else n_pass++;
        csr_read(12'h341, d);
        n_checks++; if (d !== 32'h100) $display("FAIL exc_mepc: got %h want 00000100", d); else n_pass++;
        csr_read(12'h342, d);
        n_checks++; if (d !== 32'h2) $display("FAIL exc_mcause: got %h want 2", d); else n_pass++;
        csr_read(12'h343, d);
        n_checks++; if (d !== 32'hDEAD) $display("FAIL exc_mtval: got %h want 0000dead", d); else n_pass++;
        csr_read(12'h300, d);
        n_checks++; if (d !== 32'h800) $display("FAIL exc_mpp: got %h want 00000800", d); else n_pass++;
    endtask

    task automatic test_mret();
        logic [31:0] d;
        csr_write(12'h300, 32'h0);
        csr_write(12'h341, 32'h200);
        mret = 1'b1; csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h300;
        tick();
        mret = 1'b0; csr_we = 1'b0;
        n_checks++; if (redirect_val !== 1'b1) $display("FAIL mret_rval: got %b want 1", redirect_val); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h200) $display("FAIL mret_rpc: got %h want 00000200", redirect_pc); else n_pass++;
        n_checks++; if (priv !== 1'b0) $display("FAIL mret_priv: got %b want 0", priv); else n_pass++;
        csr_read(12'h341, d);
        n_checks++; if (d !== 32'h300) $display("FAIL mret_mepc_wr: got %h want 00000300", d); else n_pass++;
        tick();
        n_checks++; if (redirect_val !== 1'b0) $display("FAIL mret_pulse: got %b want 0", redirect_val); else n_pass++;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        n_checks++; if (redirect_val !== 1'b0) $display("FAIL mret_user: got %b want 0", redirect_val); else n_pass++;
        n_checks++; if (priv !== 1'b0) $display("FAIL mret_user_priv: got %b want 0", priv); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int n = 0;
        bit saw_redirect = 1'b0;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        while (!timeout_err && n < 100) begin
            tick();
            n++;
            if (redirect_val) saw_redirect = 1'b1;
        end
        n_checks++; if (n != 64) $display("FAIL timeout_cycles: got %0d want 64", n); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL timeout_stall: got %b want 0", stall); else n_pass++;
        n_checks++; if (saw_redirect !== 1'b0) $display("FAIL timeout_redirect: got %b want 0", saw_redirect); else n_pass++;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        exc = 1'b1; exc_mepc = 32'h500; exc_mcause = 32'h7; exc_mtval = 32'hBEEF;
        tick();
        exc = 1'b0;
        n_checks++; if (redirect_val !== 1'b1 || redirect_pc !== 32'h4000)
            $display("FAIL post_to_redirect: got %b/%h want 1/00004000", redirect_val, redirect_pc);
        else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err); else n_pass++;
        n_checks++; if (priv !== 1'b1) $display("FAIL post_to_priv: got %b want 1", priv); else n_pass++;
        csr_read(12'h342, d);
        n_checks++; if (d !== 32'h7) $display("FAIL post_to_mcause: got %h want 7", d); else n_pass++;
        csr_read(12'h300, d);
        n_checks++; if (d !== 32'h0) $display("FAIL post_to_mpp: got %h want 0", d); else n_pass++;
        tick();
    endtask

    task automatic test_priority_and_reset();
        logic [31:0] d;
        kill = 1'b1; mret = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h8000;
        tick();
        kill = 1'b0; mret = 1'b0; csr_we = 1'b0;
        n_checks++; if ({flush, stall, redirect_val} !== 3'b110)
            $display("FAIL prio_outs: got %b want 110", {flush, stall, redirect_val});
        else n_pass++;
        csr_read(12'h305, d);
        n_checks++; if (d !== 32'h4000) $display("FAIL prio_mtvec: got %h want 00004000", d); else n_pass++;
        tick();
        #2;
        rsn = 1'b0;
        #1;
        n_checks++; if ({stall, flush, redirect_val, timeout_err, priv} !== 5'b00001)
            $display("FAIL async_rst: got %b want 00001", {stall, flush, redirect_val, timeout_err, priv});
        else n_pass++;
        csr_read(12'h305, d);
        n_checks++; if (d !== 32'h2000) $display("FAIL async_rst_mtvec: got %h want 00002000", d); else n_pass++;
        csr_read(12'h341, d);
        n_checks++; if (d !== 32'h0) $display("FAIL async_rst_mepc: got %h want 0", d); else n_pass++;
        tick();
        rsn = 1'b1;
        tick();
        exc = 1'b1; exc_mepc = 32'h44; exc_mcause = 32'h3; exc_mtval = 32'h0;
        tick();
        exc = 1'b0;
        n_checks++; if ({flush, stall, redirect_val} !== 3'b111 || redirect_pc !== 32'h2000)
            $display("FAIL idle_exc: got %b/%h want 111/00002000", {flush, stall, redirect_val}, redirect_pc);
        else n_pass++;
        tick();
        n_checks++; if ({flush, stall, redirect_val} !== 3'b000)
            $display("FAIL idle_exc_done: got %b want 000", {flush, stall, redirect_val});
        else n_pass++;
        csr_read(12'h341, d);
        n_checks++; if (d !== 32'h44) $display("FAIL idle_exc_mepc: got %h want 00000044", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_csr_rw();
        test_exception();
        test_mret();
        test_timeout();
        test_priority_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl_unit.md
Name: trap_ctrl_unit

Overview:
- Consumer of the history file's exception/recovery interface.
- Sequences the precise-exception response:
  - flushes the pipeline on a kill;
  - holds decode while the history file rolls back the register file;
  - captures the exception CSRs on the exception-occurred pulse;
  - redirects fetch to the trap vector.
- Also owns the machine trap CSRs, the decode-side CSR read/write port, and mret return redirection.

Parameters:
RESET_MTVEC, 32'h0000_2000, trap vector after reset
REC_TIMEOUT, 64, max cycles in WAIT_REC before abandoning recovery
CNT_W, 7, width of timeout counter (must hold REC_TIMEOUT)

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, asynchronous, active-low
hf_kill_instr_i  in  1  history file kill request (head excepted)
hf_kill_pc_i  in  32  PC of killed instruction
hf_exc_occured_i  in  1  recovery finished, exception fields valid
hf_exc_mtval_i  in  32  faulting address
hf_exc_mepc_i  in  32  faulting PC
hf_exc_mcause_i  in  32  cause code
dec_mret_i  in  1  mret in decode
dec_csr_we_i  in  1  CSR write strobe
dec_csr_addr_i  in  12  CSR address
dec_csr_wdata_i  in  32  CSR write data
dec_csr_rdata_o  out  32  CSR read data (combinational)
stall_decode_o  out  1  hold decode
flush_pipe_o  out  1  one-cycle flush of fetch..exec
redirect_val_o  out  1  one-cycle fetch redirect
redirect_pc_o  out  32  redirect target
priv_o  out  1  current privilege (1=machine, 0=user)
timeout_err_o  out  1  sticky recovery timeout flag

Behaviour:
- All outputs registered except dec_csr_rdata_o.
- Reset values:
  - outputs 0, except priv_o=1;
  - mtvec=RESET_MTVEC;
  - mepc, mcause, mtval, prev_priv = 0;
  - FSM=IDLE, counter=0.
- Reset asserted mid-sequence aborts immediately to these values.
- CSR map:
  - 0x300 mstatus: read {20'b0, prev_priv, 11'b0}, i.e. bit 11 = MPP; writes update only bit 11.
  - 0x305 mtvec: bits [1:0] forced 0.
  - 0x341 mepc, 0x342 mcause, 0x343 mtval: read/write.
  - Other addresses: read 0, writes ignored.
- CSR reads return the pre-write value in the same cycle a write occurs.
- CSR writes are accepted only in IDLE with no kill or exc_occured in the same cycle.
- FSM IDLE:
  - hf_kill_instr_i=1 -> WAIT_REC. Next cycle flush_pipe_o=1 (1 cycle) and stall_decode_o=1; counter cleared.
  - hf_exc_occured_i=1 with no prior kill -> capture (see WAIT_REC), flush_pipe_o pulse, -> REDIRECT.
  - dec_mret_i=1 and priv_o=1 -> next cycle redirect_val_o=1, redirect_pc_o=mepc, priv<=prev_priv, prev_priv<=0.
  - mret with priv_o=0 is ignored.
  - Priority: exc_occured > kill > mret > CSR write.
- FSM WAIT_REC:
  - stall_decode_o=1; counter increments each cycle.
  - On hf_exc_occured_i: mepc/mcause/mtval<=inputs, prev_priv<=priv, priv<=1, -> REDIRECT.
  - Counter reaching REC_TIMEOUT-1 without exc_occured: timeout_err_o<=1 (sticky until reset), stall released, -> IDLE, no redirect.
  - Kill and mret in this state are ignored.
- FSM REDIRECT (one cycle):
  - redirect_val_o=1, redirect_pc_o=mtvec, stall_decode_o=1.
  - Next state IDLE, stall drops.
  - Kill in this state is ignored (its history file is already drained).
- Latency:
  - exception fields to redirect: 1 cycle;
  - kill to flush: 1 cycle;
  - mret to redirect: 1 cycle.
- A CSR write to mepc in the same cycle as an mret uses the old mepc.

Decomposition:
- Shared package holds:
  - CSR address constants (CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL);
  - FSM state encoding (IDLE, WAIT_REC, REDIRECT);
  - the MPP bit index.
- One natural sub-module, trap_csr_regs: CSR storage, combinational read mux, and write decode, with a capture port driven by the FSM.

Test Plan:
- Reset, read 0x305 -> 32'h2000; write 0x305=32'h4003, read -> 32'h4000; read 0x7C0 -> 0.
- kill_pc=0x100, exc_occured 5 cycles later with mepc=0x100, mcause=2, mtval=0xDEAD:
  - flush 1 cycle after kill;
  - stall held 6 cycles;
  - redirect_pc=0x4000 one cycle after exc;
  - mepc/mcause/mtval read back 0x100/2/0xDEAD;
  - priv=1, mstatus bit11 equals the previous priv.
- Write mepc=0x200, priv=1, pulse mret -> redirect_pc=0x200 next cycle, priv=prev_priv. mret again with priv=0 -> no redirect.
- Kill with no exc_occured -> timeout_err=1 after 64 cycles, stall drops, no redirect; a following kill/exc sequence still works.
- Simultaneous kill, mret, and CSR write to mtvec in IDLE -> only kill honoured, mtvec unchanged. Async reset asserted during WAIT_REC -> all outputs at reset values immediately.
